loc2axiw: RTL

- Local-to-AXI write master that sits directly upstream of the AXI-write-to-RAM slave stage.
- Accepts one burst command (id, address, length) plus a local data stream, and drives the AXI AW and W channels.
- Waits for the matching B response, then reports completion.
- Only one burst is outstanding at a time. Used by the bench-side data mover and the DMA-like path feeding the local RAM.

---
 rtl/loc2axiw.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/loc2axiw.sv
// loc2axiw
// Local-to-AXI write master. Takes one burst command (id, byte address,
// beats-minus-one) and a local data stream, then drives AXI AW and W. It waits
// for the B response and reports completion. Only one burst is in flight.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   cmd_valid/cmd_ready        burst command handshake
//   cmd_id/cmd_addr/cmd_len    burst ID, byte start address, beats minus one
//   wdat_valid/wdat_ready      local data handshake
//   wdat_data                  local data word
//   axi_aw_*                   AXI write address channel (master side)
//   axi_w_*                    AXI write data channel (master side)
//   axi_b_id/valid/ready       AXI write response channel
//   busy                       a burst is in progress
//   done                       one-cycle pulse once B has been accepted
//   done_err                   with done: returned B ID differs from issued ID
module loc2axiw #(
    parameter int AXI_AWIDTH  = 32,
    parameter int AXI_DWIDTH  = 32,
    parameter int AXI_IDWIDTH = 3,
    parameter int AXI_LWIDTH  = 8,
    parameter int AXI_SIZE    = 3,
    parameter int AXI_STRB    = 4,
    parameter int BEAT_SIZE   = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [AXI_IDWIDTH-1:0] cmd_id,
    input  logic [AXI_AWIDTH-1:0]  cmd_addr,
    input  logic [AXI_LWIDTH-1:0]  cmd_len,
    input  logic                   wdat_valid,
    output logic                   wdat_ready,
    input  logic [AXI_DWIDTH-1:0]  wdat_data,
    output logic [AXI_IDWIDTH-1:0] axi_aw_id,
    output logic [AXI_AWIDTH-1:0]  axi_aw_addr,
    output logic [AXI_LWIDTH-1:0]  axi_aw_len,
    output logic [AXI_SIZE-1:0]    axi_aw_size,
    output logic                   axi_aw_valid,
    input  logic                   axi_aw_ready,
    output logic [AXI_DWIDTH-1:0]  axi_w_data,
    output logic [AXI_STRB-1:0]    axi_w_strb,
    output logic                   axi_w_last,
    output logic                   axi_w_valid,
    input  logic                   axi_w_ready,
    input  logic [AXI_IDWIDTH-1:0] axi_b_id,
    input  logic                   axi_b_valid,
    output logic                   axi_b_ready,
    output logic                   busy,
    output logic                   done,
    output logic                   done_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    // Word alignment: beats are always full-width, so the low byte-lane bits drop.
    localparam logic [AXI_AWIDTH-1:0] ADDR_MASK = {{(AXI_AWIDTH-2){1'b1}}, 2'b00};
    localparam logic [AXI_SIZE-1:0]   SIZE_VAL  = AXI_SIZE'(BEAT_SIZE);
    localparam logic [AXI_LWIDTH:0]   ONE_BEAT  = (AXI_LWIDTH+1)'(1);

    state_t                   state_r;
    state_t                   state_s;
    logic                     cmd_ready_r;
    logic                     busy_r;
    logic                     done_r;
    logic                     done_err_r;
    logic                     aw_valid_r;
    logic                     w_valid_r;
    logic                     w_last_r;
    logic                     b_ready_r;
    logic [AXI_IDWIDTH-1:0]   id_r;
    logic [AXI_AWIDTH-1:0]    addr_r;
    logic [AXI_LWIDTH-1:0]    len_r;
    logic [AXI_DWIDTH-1:0]    w_data_r;
    // One bit wider than len so that 2^AXI_LWIDTH loaded beats is representable.
    logic [AXI_LWIDTH:0]      beats_r;

    logic                     cmd_hs_s;
    logic                     aw_hs_s;
    logic                     w_hs_s;
    logic                     wdat_hs_s;
    logic                     b_hs_s;
    logic                     wdat_ready_s;
    logic                     last_load_s;
    logic [AXI_LWIDTH:0]      beats_total_s;

    // Handshake decode and the one-entry W output register refill condition.
    always_comb begin
        beats_total_s = {1'b0, len_r} + ONE_BEAT;
        cmd_hs_s      = cmd_valid && cmd_ready_r;
        aw_hs_s       = aw_valid_r && axi_aw_ready;
        w_hs_s        = w_valid_r && axi_w_ready;
        b_hs_s        = b_ready_r && axi_b_valid;
        wdat_ready_s  = (state_r == ST_DATA) && (!w_valid_r || axi_w_ready) &&
                        (beats_r < beats_total_s);
        wdat_hs_s     = wdat_ready_s && wdat_valid;
        last_load_s   = (beats_r == {1'b0, len_r});
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (cmd_hs_s) state_s = ST_ADDR;
                else          state_s = ST_IDLE;
            end
            ST_ADDR: begin
                if (aw_hs_s) state_s = ST_DATA;
                else         state_s = ST_ADDR;
            end
            ST_DATA: begin
                if (w_hs_s && w_last_r) state_s = ST_RESP;
                else                    state_s = ST_DATA;
            end
            ST_RESP: begin
                if (b_hs_s) state_s = ST_IDLE;
                else        state_s = ST_RESP;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_r <= ST_IDLE;
        else        state_r <= state_s;
    end

    // Command capture, channel valids, beat counter and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_ready_r <= 1'b1;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            done_err_r  <= 1'b0;
            aw_valid_r  <= 1'b0;
            w_valid_r   <= 1'b0;
            w_last_r    <= 1'b0;
            b_ready_r   <= 1'b0;
            id_r        <= {AXI_IDWIDTH{1'b0}};
            addr_r      <= {AXI_AWIDTH{1'b0}};
            len_r       <= {AXI_LWIDTH{1'b0}};
            w_data_r    <= {AXI_DWIDTH{1'b0}};
            beats_r     <= {(AXI_LWIDTH+1){1'b0}};
        end else begin
            done_r     <= 1'b0;
            done_err_r <= 1'b0;

            if (cmd_hs_s) begin
                id_r        <= cmd_id;
                addr_r      <= cmd_addr & ADDR_MASK;
                len_r       <= cmd_len;
                beats_r     <= {(AXI_LWIDTH+1){1'b0}};
                busy_r      <= 1'b1;
                cmd_ready_r <= 1'b0;
                aw_valid_r  <= 1'b1;
            end else if (aw_hs_s) begin
                aw_valid_r  <= 1'b0;
            end else begin
                aw_valid_r  <= aw_valid_r;
            end

            // A load always wins over a drain: the slot is refilled in the
            // same cycle the current beat leaves, so no bubble is inserted.
            if (wdat_hs_s) begin
                w_data_r  <= wdat_data;
                w_valid_r <= 1'b1;
                w_last_r  <= last_load_s;
                beats_r   <= beats_r + ONE_BEAT;
            end else if (w_hs_s) begin
                w_valid_r <= 1'b0;
                w_last_r  <= 1'b0;
            end else begin
                w_valid_r <= w_valid_r;
            end

            if (w_hs_s && w_last_r) begin
                b_ready_r <= 1'b1;
            end else if (b_hs_s) begin
                b_ready_r   <= 1'b0;
                done_r      <= 1'b1;
                done_err_r  <= (axi_b_id != id_r);
                busy_r      <= 1'b0;
                cmd_ready_r <= 1'b1;
            end else begin
                b_ready_r <= b_ready_r;
            end
        end
    end

    assign cmd_ready    = cmd_ready_r;
    assign wdat_ready   = wdat_ready_s;
    assign axi_aw_id    = id_r;
    assign axi_aw_addr  = addr_r;
    assign axi_aw_len   = len_r;
    assign axi_aw_size  = SIZE_VAL;
    assign axi_aw_valid = aw_valid_r;
    assign axi_w_data   = w_data_r;
    assign axi_w_strb   = {AXI_STRB{1'b1}};
    assign axi_w_last   = w_last_r;
    assign axi_w_valid  = w_valid_r;
    assign axi_b_ready  = b_ready_r;
    assign busy         = busy_r;
    assign done         = done_r;
    assign done_err     = done_err_r;

endmodule
